// File: rtl/fir_tap_sequencer.sv
// Sample delay line and tap-pair sequencer in front of a symmetric FIR MAC.
// Define FIR_ODD_TAPS_EN to allow odd N_TAPS (the centre tap is driven unpaired).
module fir_tap_sequencer #(
  parameter int WIDTH_DATA    = 8,
  parameter int N_TAPS        = 16,
  parameter int WIDTH_MAC_OUT = 8,
  parameter int ADDR_W        = $clog2((N_TAPS + 1) / 2)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH_DATA-1:0]    x_in,
  input  logic                     x_valid,
  output logic                     x_ready,
  output logic [WIDTH_DATA:0]      adder,
  output logic [ADDR_W-1:0]        coef_addr,
  output logic                     mac_clr,
  input  logic [WIDTH_MAC_OUT-1:0] mac_out,
  output logic [WIDTH_MAC_OUT-1:0] y_out,
  output logic                     y_valid,
  input  logic                     y_ready
);

`ifdef FIR_ODD_TAPS_EN
  localparam int NP = (N_TAPS + 1) / 2;
`else
  localparam int NP = N_TAPS / 2;
  generate
    if (N_TAPS % 2 != 0) begin : g_odd_taps_unsupported
      $error("fir_tap_sequencer: odd N_TAPS requires FIR_ODD_TAPS_EN");
    end
  endgenerate
`endif

  localparam int IDX_W = $clog2(N_TAPS);
  localparam logic [ADDR_W-1:0] K_LAST  = ADDR_W'(NP - 1);
  localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(N_TAPS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]               state;
  logic [ADDR_W-1:0]        k;
  logic [WIDTH_DATA-1:0]    d [N_TAPS];
  logic [WIDTH_MAC_OUT-1:0] y_reg;
  logic [IDX_W-1:0]         idx_lo;
  logic [IDX_W-1:0]         idx_hi;
  logic                     centre;

  // Unsigned pre-add of a symmetric pair; one extra bit means it cannot overflow.
  function automatic logic [WIDTH_DATA:0] pre_add(input logic [WIDTH_DATA-1:0] a,
                                                  input logic [WIDTH_DATA-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      k     <= '0;
      y_reg <= '0;
      for (int i = 0; i < N_TAPS; i++) d[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (x_valid) begin
            d[0] <= x_in;
            for (int i = 1; i < N_TAPS; i++) d[i] <= d[i-1];
            k     <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (k == K_LAST) state <= S_DRAIN;
          else             k     <= k + 1'b1;
        end
        // Last product landed on the previous edge, so mac_out is final here.
        S_DRAIN: begin
          y_reg <= mac_out;
          state <= S_OUT;
        end
        S_OUT: begin
          if (y_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign idx_lo = IDX_W'(k);
  assign idx_hi = IDX_TOP - idx_lo;

`ifdef FIR_ODD_TAPS_EN
  assign centre = (idx_lo == idx_hi);
`else
  assign centre = 1'b0;
`endif

  // Outside RUN the adder is forced to zero so the free-running MAC holds its sum.
  always_comb begin
    adder     = '0;
    coef_addr = '0;
    mac_clr   = 1'b0;
    if (state == S_RUN) begin
      coef_addr = k;
      mac_clr   = (k == '0);
      adder     = centre ? {1'b0, d[idx_lo]} : pre_add(d[idx_lo], d[idx_hi]);
    end
  end

  assign x_ready = (state == S_IDLE);
  assign y_valid = (state == S_OUT);
  assign y_out   = y_reg;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: behavioural MAC/ROM around the DUT, reference
// convolution feeding an expected-output queue.
module tb_fir_tap_sequencer;

`ifdef FIR_ODD_TAPS_EN
  localparam int NT = 3;
  localparam int C1 = 3;
`else
  localparam int NT = 4;
  localparam int C1 = 2;
`endif
  localparam int DW = 8;
  localparam int MW = 8;
  localparam int AW = $clog2((NT + 1) / 2);
  localparam int NP = (NT + 1) / 2;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] x_in;
  logic          x_valid;
  logic          x_ready;
  logic [DW:0]   adder;
  logic [AW-1:0] coef_addr;
  logic          mac_clr;
  logic [MW-1:0] mac_out;
  logic [MW-1:0] y_out;
  logic          y_valid;
  logic          y_ready;

  fir_tap_sequencer #(
    .WIDTH_DATA(DW), .N_TAPS(NT), .WIDTH_MAC_OUT(MW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .adder(adder), .coef_addr(coef_addr), .mac_clr(mac_clr), .mac_out(mac_out),
    .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coefficient ROM (async read) and free-running, unreset MAC.
  logic [7:0]    coef;
  logic [16:0]   prod;
  logic [MW-1:0] acc = 8'h5A;
  assign coef    = (coef_addr == '0) ? 8'd1 : 8'(C1);
  assign prod    = 17'(adder) * 17'(coef);
  assign mac_out = acc;
  always @(posedge clk) acc <= mac_clr ? prod[MW-1:0] : acc + prod[MW-1:0];

  int            n_vec = 0;
  int            n_err = 0;
  int            hist [NT];
  logic [MW-1:0] exp_q [$];

  function automatic int h_of(int i);
    int j;
    j = (i < NT - 1 - i) ? i : NT - 1 - i;
    return (j == 0) ? 1 : C1;
  endfunction

  function automatic int pair_of(int kk);
    return (kk == NT - 1 - kk) ? hist[kk] : hist[kk] + hist[NT - 1 - kk];
  endfunction

  task automatic ref_push(input int x);
    int sum;
    for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    sum = 0;
    for (int i = 0; i < NT; i++) sum += hist[i] * h_of(i);
    exp_q.push_back(MW'(sum));
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input int x);
    int n;
    n = 0;
    while (!x_ready && n < 40) begin tick(); n++; end
    check("x_ready_wait", 32'(x_ready), 32'd1);
    x_valid = 1'b1;
    x_in    = DW'(x);
    tick();
    x_valid = 1'b0;
    ref_push(x);
  endtask

  task automatic get_y(input string tag);
    int n;
    logic [MW-1:0] e;
    n = 0;
    while (!y_valid && n < 40) begin tick(); n++; end
    check({tag, "_valid"}, 32'(y_valid), 32'd1);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed output %0d expected none (scoreboard empty)", tag, y_out);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(y_out), 32'(e));
    end
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
  endtask

  // Accept a sample and check every cycle up to the output handshake.
  task automatic send_timed(input int x, input string tag);
    send(x);
    for (int c = 0; c < NP; c++) begin
      check({tag, "_clr"},   32'(mac_clr),   32'(c == 0));
      check({tag, "_adder"}, 32'(adder),     32'(pair_of(c)));
      check({tag, "_addr"},  32'(coef_addr), 32'(c));
      check({tag, "_xrdy"},  32'(x_ready),   32'd0);
      tick();
    end
    check({tag, "_drain_adder"}, 32'(adder),   32'd0);
    check({tag, "_drain_yv"},    32'(y_valid), 32'd0);
    tick();
    check({tag, "_out_yv"},    32'(y_valid), 32'd1);
    check({tag, "_out_xrdy"},  32'(x_ready), 32'd0);
    check({tag, "_out_adder"}, 32'(adder),   32'd0);
    get_y({tag, "_y"});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NT; i++) hist[i] = 0;
    rst_n = 1'b0; x_valid = 1'b0; x_in = '0; y_ready = 1'b0;
    tick(); tick();
    check("rst_adder",   32'(adder),     32'd0);
    check("rst_addr",    32'(coef_addr), 32'd0);
    check("rst_clr",     32'(mac_clr),   32'd0);
    check("rst_yout",    32'(y_out),     32'd0);
    check("rst_yvalid",  32'(y_valid),   32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_xready",  32'(x_ready),   32'd1);

    // Impulse response
    send_timed(10, "imp0");
    send_timed(0,  "imp1");
    send_timed(0,  "imp2");
    send_timed(0,  "imp3");
    send_timed(0,  "imp4");

    // Wrap-around of the output width
    send_timed(200, "trunc0");
    send_timed(200, "trunc1");
    send_timed(200, "trunc2");
    send_timed(200, "trunc3");

    // Backpressure with a competing sample held on x_valid
    send(5);
    for (int n = 0; n < 40 && !y_valid; n++) tick();
    x_valid = 1'b1;
    x_in    = 8'd77;
    for (int c = 0; c < 5; c++) begin
      check("bp_yvalid", 32'(y_valid), 32'd1);
      check("bp_yout",   32'(y_out),   32'(exp_q[0]));
      check("bp_xready", 32'(x_ready), 32'd0);
      check("bp_adder",  32'(adder),   32'd0);
      tick();
    end
    get_y("bp_out");
    check("bp_idle_xready", 32'(x_ready), 32'd1);
    check("bp_idle_yvalid", 32'(y_valid), 32'd0);
    tick();
    x_valid = 1'b0;
    ref_push(77);
    check("bp_take_xready", 32'(x_ready), 32'd0);
    check("bp_take_clr",    32'(mac_clr), 32'd1);
    get_y("bp_next");

    // Asynchronous reset in the middle of RUN
    send(10);
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_adder",  32'(adder),     32'd0);
    check("mrst_clr",    32'(mac_clr),   32'd0);
    check("mrst_addr",   32'(coef_addr), 32'd0);
    check("mrst_yvalid", 32'(y_valid),   32'd0);
    check("mrst_yout",   32'(y_out),     32'd0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NT; i++) hist[i] = 0;
    tick();
    check("mrst_xready", 32'(x_ready), 32'd1);
    send_timed(10, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
